// File: rtl/trace_pkg.sv
// ============================================================================
//  Module      : trace_pkg
//  Description : Shared types for the commit-trace recorder: capture modes,
//                controller states and the packed entry width helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  // Capture mode selected on arm; 2'd3 is reserved and treated as WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP      = 2'd0,
    MODE_STOP_FULL = 2'd1,
    MODE_TRIGGER   = 2'd2,
    MODE_RSVD      = 2'd3
  } trace_mode_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  // Packed entry: {ts, pc, instr, alu_result, wr_data, reg_write, branch}.
  function automatic int entry_width(input int xlen, input int ts_w);
    return 4 * xlen + 2 + ts_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_buffer_if.sv
// ============================================================================
//  Module      : trace_buffer_if
//  Description : Control, capture-tap and readout bundle of the trace buffer.
//                master = the driving side (core tap / debugger),
//                slave  = the trace_buffer itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface trace_buffer_if
  import trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int POST_W = 8
);
  localparam int EW = entry_width(XLEN, TS_W);
  localparam int CW = $clog2(DEPTH) + 1;

  // control
  logic [1:0]        mode;
  logic              arm;
  logic              stop;
  logic [XLEN-1:0]   trig_pc;
  logic [POST_W-1:0] post_cnt;
  // capture tap
  logic              cap_valid;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   instr;
  logic [XLEN-1:0]   alu_result;
  logic [XLEN-1:0]   wr_data;
  logic              reg_write;
  logic              branch;
  // readout and status
  logic              rd_en;
  logic              rd_valid;
  logic [EW-1:0]     rd_data;
  logic [CW-1:0]     count;
  logic              capturing;
  logic              triggered;
  logic              done;
  logic              overflow;

  modport master (
    output mode, arm, stop, trig_pc, post_cnt,
    output cap_valid, pc, instr, alu_result, wr_data, reg_write, branch,
    output rd_en,
    input  rd_valid, rd_data, count, capturing, triggered, done, overflow
  );

  modport slave (
    input  mode, arm, stop, trig_pc, post_cnt,
    input  cap_valid, pc, instr, alu_result, wr_data, reg_write, branch,
    input  rd_en,
    output rd_valid, rd_data, count, capturing, triggered, done, overflow
  );

endinterface

`default_nettype wire

// File: rtl/trace_ram.sv
// ============================================================================
//  Module      : trace_ram
//  Description : DEPTH x WIDTH storage, one synchronous write port and one
//                asynchronous read port. A read of the location being written
//                on the same edge returns the old contents.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 146
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/trace_buffer.sv
// ============================================================================
//  Module      : trace_buffer
//  Description : Mode-selectable commit-trace recorder (WRAP / STOP_FULL /
//                TRIGGER) with a free-running timestamp and oldest-first
//                registered pop readout.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int POST_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  trace_buffer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_width(XLEN, TS_W);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  trace_state_e      state_q, state_d;
  trace_mode_e       mode_q, mode_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [POST_W-1:0] rem_q, rem_d;
  logic              trig_q, trig_d;
  logic              ovf_q, ovf_d;
  logic [TS_W-1:0]   ts_q;
  logic              rd_valid_q;
  logic [EW-1:0]     rd_data_q;

  logic [EW-1:0]     ram_rdata;
  logic [EW-1:0]     wr_entry;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              hit;
  logic              fill_last;

  // arm wins over everything, so it also suppresses the pop and the write.
  assign full      = (count_q == FULL_CNT);
  assign pop       = bus.rd_en && (count_q != '0) && !bus.arm;
  assign wr_en     = bus.cap_valid && !bus.arm &&
                     ((state_q == ST_CAPTURE) || (state_q == ST_POST));
  assign hit       = wr_en && (state_q == ST_CAPTURE) &&
                     (mode_q == MODE_TRIGGER) && (bus.pc == bus.trig_pc);
  // The write that brings count to DEPTH (a concurrent pop keeps it below).
  assign fill_last = wr_en && !pop && (mode_q == MODE_STOP_FULL) &&
                     (count_q == LAST_CNT);
  assign wr_entry  = {ts_q, bus.pc, bus.instr, bus.alu_result, bus.wr_data,
                      bus.reg_write, bus.branch};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (tail_q),
    .wdata_i (wr_entry),
    .raddr_i (head_q),
    .rdata_o (ram_rdata)
  );

  // Next-state: pointers, occupancy, trigger bookkeeping and mode FSM.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rem_d   = rem_q;
    trig_d  = trig_q;
    ovf_d   = ovf_q;
    if (bus.arm) begin
      state_d = ST_CAPTURE;
      mode_d  = trace_mode_e'(bus.mode);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      rem_d   = bus.post_cnt;
      trig_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_en) tail_d = tail_q + 1'b1;
      // A full write pushes the oldest out; paired with a pop, head moves once.
      if (pop || (wr_en && full)) head_d = head_q + 1'b1;
      if (wr_en && full && !pop) ovf_d = 1'b1;
      if (wr_en && !full && !pop)     count_d = count_q + 1'b1;
      else if (pop && !wr_en)         count_d = count_q - 1'b1;
      case (state_q)
        ST_CAPTURE: begin
          if (hit) begin
            trig_d  = 1'b1;
            state_d = (rem_q == '0) ? ST_DONE : ST_POST;
          end else if (fill_last) begin
            state_d = ST_DONE;
          end
          if (bus.stop) state_d = ST_DONE;
        end
        ST_POST: begin
          if (wr_en) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == POST_W'(1)) state_d = ST_DONE;
          end
          if (bus.stop) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_WRAP;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rem_q   <= '0;
      trig_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      trig_q  <= trig_d;
      ovf_q   <= ovf_d;
    end
  end

  // Free-running timestamp, untouched by arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  // Registered read port: the head entry is presented the cycle after a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= pop;
      if (pop) rd_data_q <= ram_rdata;
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.count     = count_q;
  assign bus.capturing = (state_q == ST_CAPTURE) || (state_q == ST_POST);
  assign bus.triggered = trig_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire
